// File: rtl/mem_write_arbiter.sv
// mem_write_arbiter: merges framebuffer and BVH write-request streams onto one
// memory write port. Each source has its own FIFO. A registered output stage
// is loaded by round-robin arbitration and handshakes with the memory
// controller using valid/ready.
// Optional build macro: MEM_ARB_FB_PRIORITY_EN. When defined, fb wins whenever
// both FIFOs hold entries (strict priority). When undefined, the grant is
// round-robin.
module mem_write_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          fb_valid,
   input  logic [ADDR_WIDTH-1:0]         fb_addr,
   input  logic [DATA_WIDTH-1:0]         fb_data,
   output logic                          fb_ready,
   input  logic                          bvh_valid,
   input  logic [ADDR_WIDTH-1:0]         bvh_addr,
   input  logic [DATA_WIDTH-1:0]         bvh_data,
   output logic                          bvh_ready,
   output logic                          out_valid,
   output logic [ADDR_WIDTH-1:0]         out_addr,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_src,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fb_level,
   output logic [$clog2(FIFO_DEPTH):0]   bvh_level
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } req_t;

   typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

   // Index 0 = fb, index 1 = bvh throughout.
   req_t             mem_q    [2][FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q [2];
   logic [PTR_W-1:0] rd_ptr_q [2];
   logic [LVL_W-1:0] level_q  [2];

   state_t state_q, state_d;
   logic   out_valid_q, out_valid_d;
   req_t   out_req_q, out_req_d;
   logic   out_src_q, out_src_d;
   logic   last_grant_q, last_grant_d;

   req_t       in_req_c [2];
   logic [1:0] ready_c;
   logic [1:0] nonempty_c;
   logic [1:0] push_c;
   logic [1:0] pop_c;
   logic       grant_c;
   logic       load_c;

   // FIFO status and push qualification; ready depends only on the level.
   always_comb begin
      in_req_c[0] = '{addr: fb_addr,  data: fb_data};
      in_req_c[1] = '{addr: bvh_addr, data: bvh_data};
      for (int s = 0; s < 2; s++) begin
         ready_c[s]    = (level_q[s] != LVL_W'(FIFO_DEPTH));
         nonempty_c[s] = (level_q[s] != '0);
      end
      push_c = {bvh_valid, fb_valid} & ready_c;
   end

   // Output-stage FSM: arbitration, load/pop decision and next output values.
   always_comb begin
      state_d      = state_q;
      out_valid_d  = out_valid_q;
      out_req_d    = out_req_q;
      out_src_d    = out_src_q;
      last_grant_d = last_grant_q;
      pop_c        = '0;
      load_c       = 1'b0;
      grant_c      = 1'b0;

      if (nonempty_c == 2'b10) begin
         grant_c = 1'b1;
      end else if (nonempty_c == 2'b11) begin
`ifdef MEM_ARB_FB_PRIORITY_EN
         grant_c = 1'b0;
`else
         grant_c = ~last_grant_q;
`endif
      end

      case (state_q)
         S_IDLE: begin
            load_c = |nonempty_c;
         end
         S_HOLD: begin
            if (out_ready) begin
               load_c = |nonempty_c;
               if (!(|nonempty_c)) begin
                  out_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase

      if (load_c) begin
         pop_c[grant_c] = 1'b1;
         out_req_d      = mem_q[grant_c][rd_ptr_q[grant_c]];
         out_src_d      = grant_c;
         last_grant_d   = grant_c;
         out_valid_d    = 1'b1;
         state_d        = S_HOLD;
      end
   end

   // Control state: FIFO pointers/levels and the output register stage.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int s = 0; s < 2; s++) begin
            wr_ptr_q[s] <= '0;
            rd_ptr_q[s] <= '0;
            level_q[s]  <= '0;
         end
         state_q      <= S_IDLE;
         out_valid_q  <= 1'b0;
         out_req_q    <= '0;
         out_src_q    <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (push_c[s]) wr_ptr_q[s] <= wr_ptr_q[s] + PTR_W'(1);
            if (pop_c[s])  rd_ptr_q[s] <= rd_ptr_q[s] + PTR_W'(1);
            if (push_c[s] && !pop_c[s])      level_q[s] <= level_q[s] + LVL_W'(1);
            else if (!push_c[s] && pop_c[s]) level_q[s] <= level_q[s] - LVL_W'(1);
         end
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         out_req_q    <= out_req_d;
         out_src_q    <= out_src_d;
         last_grant_q <= last_grant_d;
      end
   end

   // FIFO storage; contents need no reset since levels gate every read.
   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (push_c[s]) mem_q[s][wr_ptr_q[s]] <= in_req_c[s];
      end
   end

   assign fb_ready  = ready_c[0];
   assign bvh_ready = ready_c[1];
   assign out_valid = out_valid_q;
   assign out_addr  = out_req_q.addr;
   assign out_data  = out_req_q.data;
   assign out_src   = out_src_q;
   assign fb_level  = level_q[0];
   assign bvh_level = level_q[1];

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Testbench for mem_write_arbiter: queue-based transaction model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mem_write_arbiter;

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          fb_valid = 1'b0;
   logic [AW-1:0] fb_addr = '0;
   logic [DW-1:0] fb_data = '0;
   logic          fb_ready;
   logic          bvh_valid = 1'b0;
   logic [AW-1:0] bvh_addr = '0;
   logic [DW-1:0] bvh_data = '0;
   logic          bvh_ready;
   logic          out_valid;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          out_src;
   logic          out_ready = 1'b0;
   logic [LW-1:0] fb_level;
   logic [LW-1:0] bvh_level;

   int n_checks = 0;
   int n_errors = 0;

   mem_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn),
      .fb_valid(fb_valid), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
      .bvh_valid(bvh_valid), .bvh_addr(bvh_addr), .bvh_data(bvh_data), .bvh_ready(bvh_ready),
      .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data), .out_src(out_src),
      .out_ready(out_ready), .fb_level(fb_level), .bvh_level(bvh_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction model ----------------
   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
   ent_t          fbq[$];
   ent_t          bvhq[$];
   logic          m_valid;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic          m_src;
   logic          m_last;

   always @(posedge clk or negedge resetn) begin
      bit   fb_acc, bvh_acc, can_load, pick;
      ent_t e;
      if (!resetn) begin
         fbq.delete();
         bvhq.delete();
         m_valid = 1'b0; m_addr = '0; m_data = '0; m_src = 1'b0; m_last = 1'b1;
      end else begin
         fb_acc   = fb_valid  && (fbq.size()  < DEPTH);
         bvh_acc  = bvh_valid && (bvhq.size() < DEPTH);
         can_load = (!m_valid || out_ready) && (fbq.size() > 0 || bvhq.size() > 0);
         if (can_load) begin
            if (fbq.size() > 0 && bvhq.size() > 0) begin
`ifdef MEM_ARB_FB_PRIORITY_EN
               pick = 1'b0;
`else
               pick = !m_last;
`endif
            end else begin
               pick = (fbq.size() == 0);
            end
            if (pick) e = bvhq.pop_front();
            else      e = fbq.pop_front();
            m_valid = 1'b1; m_addr = e.a; m_data = e.d; m_src = pick; m_last = pick;
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         if (fb_acc)  fbq.push_back('{a: fb_addr,  d: fb_data});
         if (bvh_acc) bvhq.push_back('{a: bvh_addr, d: bvh_data});
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("model_out_valid", out_valid, m_valid);
      if (m_valid) begin
         chk("model_out_addr", out_addr, m_addr);
         chk("model_out_data", out_data, m_data);
         chk("model_out_src",  out_src,  m_src);
      end
      chk("model_fb_ready",  fb_ready,  fbq.size()  != DEPTH);
      chk("model_bvh_ready", bvh_ready, bvhq.size() != DEPTH);
      chk("model_fb_level",  fb_level,  fbq.size());
      chk("model_bvh_level", bvh_level, bvhq.size());
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      fb_valid = 1'b0; bvh_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   logic exp_rr [8];
   logic exp_pr [8];

   initial begin
      exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      exp_pr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

      // Reset state
      @(posedge clk); #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_addr",  out_addr,  0);
      chk("rst_fb_level",  fb_level,  0);
      chk("rst_bvh_level", bvh_level, 0);
      do_reset();
      chk("rst_fb_ready",  fb_ready,  1'b1);
      chk("rst_bvh_ready", bvh_ready, 1'b1);

      // Single fb request, two-cycle latency
      repeat (3) step();
      fb_valid = 1'b1; fb_addr = 32'h100; fb_data = 32'hAA; out_ready = 1'b1;
      step();
      fb_valid = 1'b0;
      chk("t1_valid_n1", out_valid, 1'b0);
      chk("t1_level_n1", fb_level, 1);
      step();
      chk("t1_valid_n2", out_valid, 1'b1);
      chk("t1_addr",     out_addr, 32'h100);
      chk("t1_data",     out_data, 32'hAA);
      chk("t1_src",      out_src, 1'b0);
      chk("t1_level_n2", fb_level, 0);
      step();
      chk("t1_valid_n3", out_valid, 1'b0);

      // Both FIFOs preloaded with four entries each, then drained
      do_reset();
      for (int i = 0; i < 4; i++) begin
         fb_valid = 1'b1;  fb_addr = 32'h200 + 32'(i);  fb_data = 32'hF000 + 32'(i);
         bvh_valid = 1'b1; bvh_addr = 32'h300 + 32'(i); bvh_data = 32'hB000 + 32'(i);
         step();
      end
      fb_valid = 1'b0; bvh_valid = 1'b0;
      chk("t2_fb_level",  fb_level, 3);
      chk("t2_bvh_level", bvh_level, 4);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t2_valid", out_valid, 1'b1);
`ifdef MEM_ARB_FB_PRIORITY_EN
         chk("t2_src_seq", out_src, exp_pr[i]);
`else
         chk("t2_src_seq", out_src, exp_rr[i]);
`endif
         step();
      end
      chk("t2_drained", out_valid, 1'b0);

      // Back-pressure fills fb FIFO; full FIFO refuses push during a pop
      do_reset();
      for (int i = 0; i < 10; i++) begin
         fb_valid = 1'b1; fb_addr = 32'(i); fb_data = 32'h1000 + 32'(i);
         step();
      end
      chk("t3_full_level", fb_level, 8);
      chk("t3_full_ready", fb_ready, 1'b0);
      chk("t3_held_addr",  out_addr, 0);
      chk("t3_held_data",  out_data, 32'h1000);
      fb_addr = 32'd99; fb_data = 32'h99; out_ready = 1'b1;
      step();
      fb_valid = 1'b0;
      chk("t4_level_after_pop", fb_level, 7);
      chk("t4_addr_after_pop",  out_addr, 1);
      for (int k = 2; k <= 8; k++) begin
         step();
         chk("t3_order_addr", out_addr, 32'(k));
         chk("t3_order_data", out_data, 32'h1000 + 32'(k));
      end
      chk("t3_last_level", fb_level, 0);
      step();
      chk("t3_end_valid", out_valid, 1'b0);

      // Asynchronous reset mid-stream
      do_reset();
      for (int i = 0; i < 5; i++) begin
         fb_valid = (i < 4); fb_addr = 32'h400 + 32'(i); fb_data = 32'(i);
         bvh_valid = 1'b1;   bvh_addr = 32'h500 + 32'(i); bvh_data = 32'(i);
         step();
      end
      fb_valid = 1'b0; bvh_valid = 1'b0;
      chk("t5_pre_valid",     out_valid, 1'b1);
      chk("t5_pre_fb_level",  fb_level, 3);
      chk("t5_pre_bvh_level", bvh_level, 5);
      #2 resetn = 1'b0;
      #1;
      chk("t5_async_valid",     out_valid, 1'b0);
      chk("t5_async_fb_level",  fb_level, 0);
      chk("t5_async_bvh_level", bvh_level, 0);
      @(posedge clk); #1 resetn = 1'b1;
      fb_valid = 1'b1; fb_addr = 32'h600; bvh_valid = 1'b1; bvh_addr = 32'h700;
      step();
      fb_valid = 1'b0; bvh_valid = 1'b0;
      step();
      chk("t5_first_grant_valid", out_valid, 1'b1);
      chk("t5_first_grant_src",   out_src, 1'b0);
      chk("t5_first_grant_addr",  out_addr, 32'h600);
      out_ready = 1'b1;
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
